// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - raster, player and game-state signals between sequencer and its neighbours
interface game_sequencer_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_in;
  logic        is_collision_in;
  logic [7:0]  player_depth_in;
  logic [2:0]  game_state_out;
  logic [7:0]  wall_depth_out;
  logic        wall_active_out;
  logic [2:0]  wall_index_out;
  logic [15:0] frame_collisions_out;

  modport master (
    output hcount_in, vcount_in, start_in, is_collision_in, player_depth_in,
    input  game_state_out, wall_depth_out, wall_active_out, wall_index_out,
           frame_collisions_out
  );

  modport slave (
    input  hcount_in, vcount_in, start_in, is_collision_in, player_depth_in,
    output game_state_out, wall_depth_out, wall_active_out, wall_index_out,
           frame_collisions_out
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - wall advance and collision judging state machine, stepped once per video frame
module game_sequencer #(
  parameter int ACTIVE_H_PIXELS     = 1280,
  parameter int ACTIVE_LINES        = 720,
  parameter int MAX_WALL_DEPTH      = 75,
  parameter int GOAL_DEPTH_DELTA    = 10,
  parameter int FRAMES_PER_STEP     = 2,
  parameter int NUM_WALLS           = 5,
  parameter int COLLISION_THRESHOLD = 200
) (
  input logic             clk_in,
  input logic             rst_in,
  game_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, OVER, WIN} state_t;

  localparam logic [10:0] H_ACT       = 11'(ACTIVE_H_PIXELS);
  localparam logic [9:0]  V_ACT       = 10'(ACTIVE_LINES);
  localparam logic [7:0]  DEPTH_MAX   = 8'(MAX_WALL_DEPTH);
  localparam logic [8:0]  DELTA       = 9'(GOAL_DEPTH_DELTA);
  localparam logic [15:0] STEP_FRAMES = 16'(FRAMES_PER_STEP);
  localparam logic [2:0]  LAST_WALL   = 3'(NUM_WALLS - 1);
  localparam logic [15:0] THRESH      = 16'(COLLISION_THRESHOLD);

  state_t      state_q, state_d;
  logic [7:0]  depth_q, depth_d;
  logic [2:0]  index_q, index_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] pix_q;
  logic [15:0] latched_q;

  logic        tick;
  logic        counted;
  logic [8:0]  depth_diff;
  logic        fail;
  logic [15:0] frame_inc;

  // Tick marks the first cycle of vertical blank, so it never overlaps a counted pixel
  assign tick    = (bus.hcount_in == 11'd0) && (bus.vcount_in == V_ACT);
  assign counted = bus.is_collision_in && (bus.hcount_in < H_ACT) && (bus.vcount_in < V_ACT);

  assign depth_diff = (depth_q >= bus.player_depth_in)
                    ? ({1'b0, depth_q} - {1'b0, bus.player_depth_in})
                    : ({1'b0, bus.player_depth_in} - {1'b0, depth_q});
  // Judge against the count being latched on this tick, i.e. the frame that just ended
  assign fail      = (depth_diff <= DELTA) && (pix_q >= THRESH);
  assign frame_inc = frame_q + 16'd1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      depth_q <= DEPTH_MAX;
      index_q <= 3'd0;
      frame_q <= 16'd0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      index_q <= index_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    index_d = index_q;
    frame_d = frame_q;
    case (state_q)
      IDLE, OVER, WIN: begin
        if (bus.start_in) begin
          state_d = RUN;
          depth_d = DEPTH_MAX;
          index_d = 3'd0;
          frame_d = 16'd0;
        end
      end
      RUN: begin
        if (tick) begin
          if (fail) begin
            state_d = OVER;
          end else if (frame_inc == STEP_FRAMES) begin
            frame_d = 16'd0;
            // Depth 1 -> 0 means the wall has passed the player; 0 is never shown
            if (depth_q == 8'd1) begin
              if (index_q == LAST_WALL) begin
                state_d = WIN;
              end else begin
                index_d = index_q + 3'd1;
                depth_d = DEPTH_MAX;
              end
            end else begin
              depth_d = depth_q - 8'd1;
            end
          end else begin
            frame_d = frame_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_q     <= 16'd0;
      latched_q <= 16'd0;
    end else if (tick) begin
      latched_q <= pix_q;
      pix_q     <= 16'd0;
    end else if (counted && (pix_q != 16'hFFFF)) begin
      pix_q <= pix_q + 16'd1;
    end
  end

  always_comb begin
    bus.game_state_out = 3'd1;
    case (state_q)
      OVER:    bus.game_state_out = 3'd0;
      WIN:     bus.game_state_out = 3'd2;
      default: bus.game_state_out = 3'd1;
    endcase
  end

  assign bus.wall_active_out      = (state_q == RUN);
  assign bus.wall_depth_out       = depth_q;
  assign bus.wall_index_out       = index_q;
  assign bus.frame_collisions_out = latched_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized frame stimulus for game_sequencer checked against a frame-level model
module tb_game_sequencer;
  localparam int A_H  = 1280;
  localparam int A_V  = 720;
  localparam int MAXD = 75;
  localparam int DLT  = 10;
  localparam int FPS  = 2;
  localparam int NW   = 5;
  localparam int TH   = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_sequencer_if bus ();

  game_sequencer #(
    .ACTIVE_H_PIXELS(A_H), .ACTIVE_LINES(A_V), .MAX_WALL_DEPTH(MAXD),
    .GOAL_DEPTH_DELTA(DLT), .FRAMES_PER_STEP(FPS), .NUM_WALLS(NW),
    .COLLISION_THRESHOLD(TH)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 running, 2 over, 3 win; depth derived from frames survived on this wall
  int m_state, m_idx, m_run, m_cnt, m_fc;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_depth();
    return MAXD - m_run / FPS;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_idx = 0; m_run = 0; m_cnt = 0; m_fc = 0;
  endfunction

  function automatic void model_edge(input int h, input int v, input bit c, input bit s, input int pd);
    bit tk = (h == 0) && (v == A_V);
    int frame_cnt = m_cnt;
    int d, diff;
    if (tk) begin
      m_fc  = m_cnt;
      m_cnt = 0;
    end else if (c && h < A_H && v < A_V && m_cnt < 65535) begin
      m_cnt++;
    end
    if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_idx = 0; m_run = 0;
      end
    end else if (tk) begin
      d    = m_depth();
      diff = (d > pd) ? d - pd : pd - d;
      if (diff <= DLT && frame_cnt >= TH) m_state = 2;
      else if (m_run + 1 == FPS * MAXD) begin
        if (m_idx == NW - 1) m_state = 3;
        else begin
          m_idx++;
          m_run = 0;
        end
      end else m_run++;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".state"}, int'(bus.game_state_out), (m_state == 2) ? 0 : ((m_state == 3) ? 2 : 1));
    check({tag, ".depth"}, int'(bus.wall_depth_out), m_depth());
    check({tag, ".active"}, int'(bus.wall_active_out), (m_state == 1) ? 1 : 0);
    check({tag, ".index"}, int'(bus.wall_index_out), m_idx);
    check({tag, ".fcoll"}, int'(bus.frame_collisions_out), m_fc);
  endtask

  task automatic drive(input int h, input int v, input bit c, input bit s);
    bus.hcount_in       = 11'(h);
    bus.vcount_in       = 10'(v);
    bus.is_collision_in = c;
    bus.start_in        = s;
    @(posedge clk);
    #1;
    model_edge(h, v, c, s, int'(bus.player_depth_in));
    bus.hcount_in       = 11'd1;
    bus.vcount_in       = 10'd1;
    bus.is_collision_in = 1'b0;
    bus.start_in        = 1'b0;
  endtask

  // ncoll counted collision pixels mixed with nfill uncounted cycles, then the frame tick
  task automatic run_frame(input int ncoll, input int nfill);
    int c = ncoll;
    int f = nfill;
    while (c > 0 || f > 0) begin
      if (c > 0 && (f == 0 || $urandom_range(0, 1) == 1)) begin
        drive($urandom_range(0, A_H - 1), $urandom_range(0, A_V - 1), 1'b1, 1'b0);
        c--;
      end else begin
        case ($urandom_range(0, 2))
          0: drive($urandom_range(0, A_H - 1), $urandom_range(0, A_V - 1), 1'b0, 1'b0);
          1: drive($urandom_range(A_H, 2047), $urandom_range(0, 1023), 1'b1, 1'b0);
          default: drive($urandom_range(0, 2047), $urandom_range(A_V + 1, 1023), 1'b1, 1'b0);
        endcase
        f--;
      end
    end
    check_all("pre_tick");
    drive(0, A_V, 1'b0, 1'b0);
    check_all("post_tick");
  endtask

  initial begin
    bus.hcount_in       = 11'd1;
    bus.vcount_in       = 10'd1;
    bus.is_collision_in = 1'b0;
    bus.start_in        = 1'b0;
    bus.player_depth_in = 8'd0;
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive(5, 5, 1'b0, 1'b1);
    check_all("start");
    check("start.active", int'(bus.wall_active_out), 1);

    for (int i = 0; i < 10; i++) run_frame(0, $urandom_range(0, 3));
    check("ten_frames.depth", int'(bus.wall_depth_out), 70);

    bus.player_depth_in = 8'd60;
    run_frame(250, 3);
    check("judged_250.fcoll", int'(bus.frame_collisions_out), 250);
    check("judged_250.state", int'(bus.game_state_out), 0);

    drive(5, 5, 1'b0, 1'b1);
    check_all("restart");
    for (int i = 0; i < 8; i++) run_frame(0, 1);
    check("depth71", int'(bus.wall_depth_out), 71);
    run_frame(250, 2);
    check("unjudged_250.state", int'(bus.game_state_out), 1);

    drive(7, 7, 1'b0, 1'b1);
    check_all("start_in_run");

    drive(10, 10, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_rst");

    drive(5, 5, 1'b0, 1'b1);
    bus.player_depth_in = 8'd200;
    for (int i = 0; i < (NW - 1) * FPS * MAXD + FPS * (MAXD - 1); i++) run_frame(0, 0);
    check("last_wall.index", int'(bus.wall_index_out), NW - 1);
    check("last_wall.depth", int'(bus.wall_depth_out), 1);
    bus.player_depth_in = 8'd1;
    run_frame(TH - 1, 1);
    check("below_thresh.state", int'(bus.game_state_out), 1);
    run_frame(TH, 1);
    check("last_step_fail.state", int'(bus.game_state_out), 0);

    drive(5, 5, 1'b0, 1'b1);
    check("restart2.index", int'(bus.wall_index_out), 0);
    check("restart2.depth", int'(bus.wall_depth_out), 75);
    bus.player_depth_in = 8'd200;
    for (int i = 0; i < NW * FPS * MAXD; i++) run_frame(0, 0);
    check("win.state", int'(bus.game_state_out), 2);

    drive(0, A_V, 1'b0, 1'b1);
    check_all("start_on_tick");
    check("start_on_tick.depth", int'(bus.wall_depth_out), 75);

    for (int i = 0; i < 300; i++) begin
      bus.player_depth_in = 8'($urandom_range(0, 90));
      if ($urandom_range(0, 2) == 0) drive(3, 3, 1'b0, 1'b1);
      if ($urandom_range(0, 9) == 0) run_frame($urandom_range(180, 260), $urandom_range(0, 4));
      else run_frame($urandom_range(0, 20), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
